// File: rtl/decode_operand_stage.sv
// ID stage of the RV32I pipeline: operand decode, EX/MEM forwarding, load-use bubbles and the ID/EX register.
// Define WB_BYPASS_EN to add a writeback forwarding tier for register files without write-before-read.
module decode_operand_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [31:0]      i_Instr,
    input  logic [XLEN-1:0]  i_PC,
    input  logic             i_Flush,
    output logic [4:0]       o_rAddr_1,
    output logic [4:0]       o_rAddr_2,
    input  logic [XLEN-1:0]  i_rData_1,
    input  logic [XLEN-1:0]  i_rData_2,
    input  logic             i_Ex_RegWrite,
    input  logic             i_Ex_IsLoad,
    input  logic [4:0]       i_Ex_Rd,
    input  logic [XLEN-1:0]  i_Ex_Result,
    input  logic             i_Mem_RegWrite,
    input  logic [4:0]       i_Mem_Rd,
    input  logic [XLEN-1:0]  i_Mem_Result,
    input  logic             i_Wb_wEnable,
    input  logic [4:0]       i_Wb_Rd,
    input  logic [XLEN-1:0]  i_Wb_Data,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [XLEN-1:0]  o_PC,
    output logic [31:0]      o_Instr,
    output logic [4:0]       o_Rd,
    output logic [XLEN-1:0]  o_Rs1Data,
    output logic [XLEN-1:0]  o_Rs2Data,
    output logic [CNT_W-1:0] o_StallCount
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, dec_rd;
    logic            rs1_used, rs2_used;
    logic            hazard, advance;
    logic signed [XLEN-1:0] op1, op2;

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [4:0]       rd_q, rd_d;
    logic signed [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // First matching producer wins; x0 is hard-wired to zero.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf_data);
        logic [XLEN-1:0] r;
        r = rf_data;
        if (rs == 5'd0)
            r = '0;
        else if (i_Ex_RegWrite && !i_Ex_IsLoad && i_Ex_Rd == rs)
            r = i_Ex_Result;
        else if (i_Mem_RegWrite && i_Mem_Rd == rs)
            r = i_Mem_Result;
`ifdef WB_BYPASS_EN
        else if (i_Wb_wEnable && i_Wb_Rd == rs)
            r = i_Wb_Data;
`endif
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic load_use(input logic used, input logic [4:0] rs);
        return used && (rs != 5'd0) && i_Ex_RegWrite && i_Ex_IsLoad && (i_Ex_Rd == rs);
    endfunction

`ifndef WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{i_Wb_wEnable, i_Wb_Rd, i_Wb_Data};
`endif

    always_comb begin
        opcode   = i_Instr[6:0];
        rs1      = i_Instr[19:15];
        rs2      = i_Instr[24:20];
        rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        rs2_used = (opcode == OP_RTYPE || opcode == OP_STORE || opcode == OP_BRANCH);
        dec_rd   = (opcode == OP_STORE || opcode == OP_BRANCH) ? 5'd0 : i_Instr[11:7];
        op1      = fwd(rs1, i_rData_1);
        op2      = fwd(rs2, i_rData_2);
        hazard   = i_Valid && (load_use(rs1_used, rs1) || load_use(rs2_used, rs2));
        advance  = !valid_q || i_Ready;
    end

    // Next state: flush beats stall, stall holds, hazard inserts a bubble.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        cnt_d   = cnt_q;
        if (i_Flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            if (hazard) begin
                valid_d = 1'b0;
                cnt_d   = sat_inc(cnt_q);
            end else begin
                valid_d = i_Valid;
                pc_d    = i_PC;
                instr_d = i_Instr;
                rd_d    = dec_rd;
                rs1_d   = op1;
                rs2_d   = op2;
            end
        end
    end

    // ID/EX register boundary
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Ready      = i_Flush || (advance && !hazard);
    assign o_rAddr_1    = rs1;
    assign o_rAddr_2    = rs2;
    assign o_Valid      = valid_q;
    assign o_PC         = pc_q;
    assign o_Instr      = instr_q;
    assign o_Rd         = rd_q;
    assign o_Rs1Data    = rs1_q;
    assign o_Rs2Data    = rs2_q;
    assign o_StallCount = cnt_q;

endmodule
